hamming_window_ctrl: RTL and testbench

Streaming window sequencer that sits between the sample source and the FFT input. It counts accepted samples within a 2048-point frame and drives the address of the single-port window-coefficient ROM (`hamming`; 1-cycle read latency, no output register, clk_en tied high). It multiplies each sample by its coefficient and presents windowed samples, tagged with frame start/end, over a valid/ready stream with full backpressure.

---
 rtl/fft_pkg.sv | 13 +
 rtl/hamming_window_ctrl_if.sv | 26 ++
 rtl/hamming_window_ctrl_win_mult.sv | 24 ++
 rtl/hamming_window_ctrl.sv | 125 ++++++++++++
 tb/tb_hamming_window_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT front-end constants and small helpers.
package fft_pkg;

  localparam int unsigned FFT_ADDR_W = 11;
  localparam int unsigned WIN_COEF_W = 12;
  localparam int unsigned FFT_DATA_W = 16;

  // Half an output LSB, added before dropping frac_w fractional bits.
  function automatic int unsigned round_const(input int unsigned frac_w);
    return 32'd1 << (frac_w - 1);
  endfunction

endpackage

// File: rtl/hamming_window_ctrl_if.sv
// Sample-in / windowed-sample-out stream pair of the window sequencer.
// master: the environment side (source + sink); slave: the sequencer.
interface hamming_window_ctrl_if import fft_pkg::*; #(
  parameter int unsigned DATA_WIDTH = FFT_DATA_W
) ();

  logic                         s_valid;
  logic                         s_ready;
  logic signed [DATA_WIDTH-1:0] s_data;
  logic                         m_valid;
  logic                         m_ready;
  logic signed [DATA_WIDTH-1:0] m_data;
  logic                         m_sof;
  logic                         m_eof;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_sof, m_eof
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_sof, m_eof
  );

endinterface

// File: rtl/hamming_window_ctrl_win_mult.sv
// Signed sample times unsigned Q0.COEF_WIDTH coefficient, round-half-up, one DSP.
module win_mult import fft_pkg::*; #(
  parameter int unsigned DATA_WIDTH = FFT_DATA_W,
  parameter int unsigned COEF_WIDTH = WIN_COEF_W
) (
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  input  logic        [COEF_WIDTH-1:0] coef_i,
  output logic signed [DATA_WIDTH-1:0] prod_o
);

  localparam int unsigned ProdWidth = DATA_WIDTH + COEF_WIDTH + 1;
  localparam logic signed [ProdWidth-1:0] RoundK = ProdWidth'(round_const(COEF_WIDTH));

  logic signed [ProdWidth-1:0] prod;
  logic signed [ProdWidth-1:0] prod_rnd;

  // Coefficient is below 1.0, so the truncated result always fits DATA_WIDTH.
  always_comb begin
    prod     = ProdWidth'(sample_i) * ProdWidth'($signed({1'b0, coef_i}));
    prod_rnd = prod + RoundK;
    prod_o   = DATA_WIDTH'(prod_rnd >>> COEF_WIDTH);
  end

endmodule

// File: rtl/hamming_window_ctrl.sv
// Streaming window sequencer: indexes samples within a frame, addresses the
// coefficient ROM and emits windowed samples tagged with frame start/end.
module hamming_window_ctrl import fft_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = FFT_ADDR_W,
  parameter int unsigned COEF_WIDTH = WIN_COEF_W,
  parameter int unsigned DATA_WIDTH = FFT_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  cfg_bypass,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [COEF_WIDTH-1:0] rom_rd_data,
  output logic                  frame_done,
  hamming_window_ctrl_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = '1;

  logic [ADDR_WIDTH-1:0]        cnt_q;
  logic                         bypass_lat_q;
  logic                         s1_valid_q;
  logic signed [DATA_WIDTH-1:0] s1_data_q;
  logic [ADDR_WIDTH-1:0]        s1_idx_q;
  logic                         s1_byp_q;
  logic                         m_valid_q;
  logic signed [DATA_WIDTH-1:0] m_data_q;
  logic                         m_sof_q;
  logic                         m_eof_q;
  logic                         frame_done_q;

  logic                         clr;
  logic                         adv;
  logic                         xfer;
  logic                         frame_start;
  logic                         byp_now;
  logic signed [DATA_WIDTH-1:0] win_data;

  assign clr         = rst || flush;
  assign adv         = !m_valid_q || bus.m_ready;
  assign bus.s_ready = !clr && (!s1_valid_q || adv);
  assign xfer        = bus.s_valid && bus.s_ready;
  assign frame_start = (cnt_q == '0);
  // Index 0 sees the live bypass setting; the rest of the frame sees the latch.
  assign byp_now     = frame_start ? cfg_bypass : bypass_lat_q;
  // A stalled S1 keeps re-reading its own coefficient so the ROM output stays valid.
  assign rom_addr    = (s1_valid_q && !adv) ? s1_idx_q : cnt_q;

  // Frame index of the next accepted sample; wraps with no gap.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (xfer) begin
      cnt_q <= cnt_q + ADDR_WIDTH'(1);
    end
  end

  // Bypass setting captured at frame start and held for the frame.
  always_ff @(posedge clk) begin
    if (clr) begin
      bypass_lat_q <= 1'b0;
    end else if (xfer && frame_start) begin
      bypass_lat_q <= cfg_bypass;
    end
  end

  // S1: accepted sample waiting for its coefficient.
  always_ff @(posedge clk) begin
    if (clr) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_idx_q   <= '0;
      s1_byp_q   <= 1'b0;
    end else if (xfer) begin
      s1_valid_q <= 1'b1;
      s1_data_q  <= bus.s_data;
      s1_idx_q   <= cnt_q;
      s1_byp_q   <= byp_now;
    end else if (adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  win_mult #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEF_WIDTH (COEF_WIDTH)
  ) u_win_mult (
    .sample_i (s1_data_q),
    .coef_i   (rom_rd_data),
    .prod_o   (win_data)
  );

  // S2: output register; payload frozen while the downstream stalls.
  always_ff @(posedge clk) begin
    if (clr) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sof_q   <= 1'b0;
      m_eof_q   <= 1'b0;
    end else if (adv) begin
      m_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        m_data_q <= s1_byp_q ? s1_data_q : win_data;
        m_sof_q  <= (s1_idx_q == '0);
        m_eof_q  <= (s1_idx_q == LastIdx);
      end
    end
  end

  // One pulse in the cycle after the last sample of a frame leaves.
  always_ff @(posedge clk) begin
    if (clr) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= m_valid_q && bus.m_ready && m_eof_q;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_sof   = m_sof_q;
  assign bus.m_eof   = m_eof_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_hamming_window_ctrl.sv
// Bench for hamming_window_ctrl: queue-based reference model checked every
// cycle, plus directed literal checks for latency, extremes, bypass, flush, reset.
module tb_hamming_window_ctrl;

  localparam int N = 2048;
  localparam real PI = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        cfg_bypass;
  logic [10:0] rom_addr;
  logic [11:0] rom_rd_data;
  logic        frame_done;

  hamming_window_ctrl_if bus ();

  hamming_window_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .cfg_bypass  (cfg_bypass),
    .rom_addr    (rom_addr),
    .rom_rd_data (rom_rd_data),
    .frame_done  (frame_done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Coefficient ROM: Hamming table or a forced constant, one-cycle read.
  logic [11:0] coef [N];
  bit          rom_mode = 1'b0;
  logic [11:0] rom_k    = '0;

  always @(posedge clk) rom_rd_data <= rom_mode ? rom_k : coef[rom_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model state.
  typedef struct {
    logic signed [15:0] data;
    bit                 sof;
    bit                 eof;
    int                 idx;
  } exp_t;

  exp_t q[$];
  bit   mon_en    = 1'b0;
  int   mdl_idx   = 0;
  bit   frame_byp = 1'b0;
  int   n_acc     = 0;
  int   n_eof     = 0;
  int   fd_count  = 0;
  bit   fd_exp    = 1'b0;
  bit   hold_v    = 1'b0;
  logic signed [15:0] hold_d;
  bit   hold_sof;
  bit   hold_eof;

  function automatic logic signed [15:0] model_out(input logic signed [15:0] s, input int idx,
                                                   input bit byp);
    longint c;
    longint p;
    if (byp) return s;
    c = rom_mode ? longint'(rom_k) : longint'(coef[idx]);
    p = longint'(s) * c;
    return 16'((p + 2048) >>> 12);
  endfunction

  // Compare process: inputs are driven just after posedge, so negedge sees
  // exactly what the next posedge will act on.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("frame_done", frame_done, fd_exp);
      fd_exp = 1'b0;
      if (frame_done) fd_count++;
      if (rst || flush) begin
        chk("s_ready_clr", bus.s_ready, 0);
        q.delete();
        mdl_idx   = 0;
        frame_byp = 1'b0;
        hold_v    = 1'b0;
      end else begin
        chk("s_ready", bus.s_ready, (q.size() == 2 && !bus.m_ready) ? 0 : 1);
        if (hold_v) begin
          chk("hold_valid", bus.m_valid, 1);
          chk("hold_data", bus.m_data, hold_d);
          chk("hold_sof", bus.m_sof, hold_sof);
          chk("hold_eof", bus.m_eof, hold_eof);
        end
        if (q.size() == 2 && !bus.m_ready) chk("rom_addr_stall", rom_addr, q[1].idx);
        if (bus.m_valid && bus.m_ready) begin
          chk("out_expected", q.size() > 0, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_data", bus.m_data, e.data);
            chk("out_sof", bus.m_sof, e.sof);
            chk("out_eof", bus.m_eof, e.eof);
            if (e.eof) begin
              fd_exp = 1'b1;
              n_eof++;
            end
          end
        end
        hold_v   = bus.m_valid && !bus.m_ready;
        hold_d   = bus.m_data;
        hold_sof = bus.m_sof;
        hold_eof = bus.m_eof;
        if (bus.s_valid && bus.s_ready) begin
          if (mdl_idx == 0) frame_byp = cfg_bypass;
          e.data = model_out(bus.s_data, mdl_idx, frame_byp);
          e.sof  = (mdl_idx == 0);
          e.eof  = (mdl_idx == N - 1);
          e.idx  = mdl_idx;
          q.push_back(e);
          mdl_idx = (mdl_idx + 1) % N;
          n_acc++;
        end
        chk("occupancy", q.size() <= 2, 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one sample into an idle pipe and check the windowed result literally.
  task automatic send_one(input string name, input logic signed [15:0] v,
                          input logic signed [15:0] req, input bit sof);
    bit got = 1'b0;
    bus.s_data  = v;
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    step();
    bus.s_valid = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (bus.m_valid) got = 1'b1;
    end
    chk({name, "_seen"}, got, 1);
    if (got) begin
      chk(name, bus.m_data, req);
      chk({name, "_sof"}, bus.m_sof, sof);
    end
    step();
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_m_valid"}, bus.m_valid, 0);
    chk({name, "_m_data"}, bus.m_data, 0);
    chk({name, "_m_sof"}, bus.m_sof, 0);
    chk({name, "_m_eof"}, bus.m_eof, 0);
    chk({name, "_frame_done"}, frame_done, 0);
    chk({name, "_rom_addr"}, rom_addr, 0);
  endtask

  initial begin
    int start;
    int cyc;
    for (int i = 0; i < N; i++) begin
      coef[i] = 12'($rtoi(4095.0 * (0.54 - 0.46 * $cos(2.0 * PI * i / 2047.0)) + 0.5));
    end
    rst         = 1'b1;
    flush       = 1'b0;
    cfg_bypass  = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_s_ready", bus.s_ready, 1);
    step();
    mon_en = 1'b1;

    // Continuous stream of 0x4000: latency, first value, one frame_done.
    bus.m_ready = 1'b1;
    bus.s_data  = 16'sh4000;
    bus.s_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("latency_early", bus.m_valid, 0);
    @(negedge clk);
    chk("latency_valid", bus.m_valid, 1);
    chk("first_data", bus.m_data, 1312);
    chk("first_sof", bus.m_sof, 1);
    repeat (2049) @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    repeat (4) step();
    chk("stream_frame_done_count", fd_count, 1);

    // Random valid/ready over three frames.
    start = n_acc;
    cyc   = 0;
    while (n_acc < start + 3 * N && cyc < 40000) begin
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.s_data  = 16'($urandom);
      bus.m_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    chk("random_budget", cyc < 40000, 1);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    repeat (5) step();
    chk("random_drain", q.size(), 0);
    chk("random_frame_done_count", fd_count, n_eof);

    // Extremes with a forced coefficient.
    flush = 1'b1;
    step();
    flush    = 1'b0;
    rom_mode = 1'b1;
    rom_k    = 12'd4095;
    send_one("ext_neg", -16'sd32768, -16'sd32760, 1'b1);
    send_one("ext_pos", 16'sd32767, 16'sd32759, 1'b0);
    rom_k = 12'd1;
    send_one("ext_m1", -16'sd1, 16'sd0, 1'b0);
    rom_mode = 1'b0;

    // Bypass raised at index 100 takes effect only from the next frame.
    flush = 1'b1;
    step();
    flush       = 1'b0;
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    start       = n_acc;
    cyc         = 0;
    while (n_acc < start + N + 200 && cyc < 5000) begin
      if (mdl_idx == 100 && n_acc - start < N) cfg_bypass = 1'b1;
      bus.s_data = 16'($urandom);
      step();
      cyc++;
    end
    chk("bypass_budget", cyc < 5000, 1);
    bus.s_valid = 1'b0;
    cfg_bypass  = 1'b0;
    repeat (3) step();
    send_one("bypass_pin", 16'sh1234, 16'sh1234, 1'b0);

    // Flush with both stages full and the sink stalled near index 700.
    flush = 1'b1;
    step();
    flush       = 1'b0;
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    cyc         = 0;
    while (mdl_idx != 700 && cyc < 3000) begin
      bus.s_data = 16'($urandom);
      step();
      cyc++;
    end
    chk("flush_budget", cyc < 3000, 1);
    bus.m_ready = 1'b0;
    repeat (3) step();
    chk("flush_full_s_ready", bus.s_ready, 0);
    flush = 1'b1;
    step();
    flush       = 1'b0;
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("flush_m_valid", bus.m_valid, 0);
    step();
    send_one("flush_restart", 16'sh4000, 16'sd1312, 1'b1);

    // Reset in mid-frame under random backpressure.
    bus.s_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.s_data  = 16'($urandom);
      bus.m_ready = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b1;
    step();
    @(negedge clk);
    check_reset_vals("midrst");
    step();
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("midrst_s_ready", bus.s_ready, 1);
    step();
    repeat (3) step();
    chk("final_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
